rotate_sequencer: RTL and testbench

- Multi-step rotate controller wrapped around the team's 8-bit single-step rotator (one-bit rotate per pass, direction-selectable).
- Accepts a request (data, direction, amount) over a valid/ready handshake.
- Iterates the rotator once per clock until the requested amount is consumed, then presents the result on a valid/ready output.
- Sits in the ALU units group, between issue logic and the writeback mux.

---
 rtl/rotate_sequencer.sv | 112 +++++++++++
 tb/tb_rotate_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rotate_sequencer.sv
// rtl/rotate_sequencer.sv - multi-step 8-bit rotate sequencer built on a single-step rotator
// Optional macro ROT_MOD_REDUCE_EN: reduce the requested amount mod 8 to shorten latency.

module rotate_step (
  input  logic [7:0] din,
  input  logic       dir,
  output logic [7:0] dout
);
  // dir = 1 rotates right (bit0 -> bit7), dir = 0 rotates left (bit7 -> bit0)
  assign dout = dir ? {din[0], din[7:1]} : {din[6:0], din[7]};
endmodule

module rotate_sequencer #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_dir,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       work;
  logic [7:0]       work_next;
  logic [AMT_W-1:0] count;
  logic [AMT_W-1:0] amt_eff;
  logic             rot_dir;

`ifdef ROT_MOD_REDUCE_EN
  // Rotating by 8 is the identity on an 8-bit value, so only the low 3 bits matter.
  assign amt_eff = in_amt & AMT_W'(7);
`else
  assign amt_eff = in_amt;
`endif

  rotate_step u_step (
    .din  (work),
    .dir  (rot_dir),
    .dout (work_next)
  );

  assign out_data = work;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      work      <= 8'h00;
      count     <= '0;
      rot_dir   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            rot_dir  <= in_dir;
            count    <= amt_eff;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (amt_eff == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          work <= work_next;
          // The count never goes below zero; count <= 1 marks the final step.
          if (count <= AMT_W'(1)) begin
            count     <= '0;
            state     <= HOLD;
            out_valid <= 1'b1;
          end else begin
            count <= count - AMT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb/tb_rotate_sequencer.sv - self-checking bench for rotate_sequencer
// Honours ROT_MOD_REDUCE_EN the same way as the design when computing latency.

module tb_rotate_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic [3:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotate_sequencer #(.AMT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] d, input logic dr, input int n);
    logic [15:0] x;
    int m;
    m = n % 8;
    if (dr) begin
      x = {d, d} >> m;
      return x[7:0];
    end
    x = {d, d} << m;
    return x[15:8];
  endfunction

  function automatic int eff_amt(input logic [3:0] a);
`ifdef ROT_MOD_REDUCE_EN
    return int'(a) % 8;
`else
    return int'(a);
`endif
  endfunction

  // Model: an operation is outstanding from its acceptance edge until the
  // result handshake; the result is visible k edges after acceptance.
  int         edge_count = 0;
  bit         busy_m = 0;
  int         t_acc = 0;
  int         k_m = 0;
  logic [7:0] res_m = 8'h00;
  int         prev_acc = 0;
  bit         acc_seen = 0;
  int         last_gap = 0;

  always @(posedge clk) begin
    int e;
    e = edge_count;
    if (reset) begin
      busy_m = 0;
    end else if (!busy_m) begin
      if (in_valid) begin
        busy_m = 1;
        t_acc  = e;
        k_m    = eff_amt(in_amt);
        res_m  = rot(in_data, in_dir, int'(in_amt));
        if (acc_seen) last_gap = e - prev_acc;
        prev_acc = e;
        acc_seen = 1;
      end
    end else if ((e - 1 - t_acc) >= k_m && out_ready) begin
      busy_m = 0;
    end
    edge_count = e + 1;
  end

  always @(negedge clk) begin
    bit exp_valid;
    if (edge_count > 0) begin
      exp_valid = busy_m && ((edge_count - 1 - t_acc) >= k_m);
      check("cyc_in_ready", in_ready, !busy_m);
      check("cyc_busy", busy, busy_m);
      check("cyc_out_valid", out_valid, exp_valid);
      if (exp_valid) check("cyc_out_data", out_data, res_m);
    end
  end

  task automatic send(input logic [7:0] d, input logic dr, input logic [3:0] a,
                      input logic [7:0] exp_d, input int exp_lat, input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_dir = dr; in_amt = a;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({nm, "_accept_timeout"}, n >= 100, 0);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0; in_amt = 4'h0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({nm, "_latency"}, n, exp_lat);
    check({nm, "_data"}, out_data, exp_d);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0; in_amt = 4'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 8'h00);
    reset = 1'b0;

    check("model_rol1", rot(8'h81, 0, 1), 8'h03);
    check("model_ror3", rot(8'h01, 1, 3), 8'h20);
    check("model_rol9", rot(8'h01, 0, 9), 8'h02);

    send(8'h81, 1'b0, 4'd1, 8'h03, 1, "rol1");
    send(8'h01, 1'b1, 4'd3, 8'h20, 3, "ror3");
    send(8'hA5, 1'b0, 4'd0, 8'hA5, 0, "zero");
`ifdef ROT_MOD_REDUCE_EN
    send(8'h01, 1'b0, 4'd9, 8'h02, 1, "large");
`else
    send(8'h01, 1'b0, 4'd9, 8'h02, 9, "large");
`endif
    send(8'hC3, 1'b1, 4'd15, 8'h87, eff_amt(4'd15), "max");

    // Back-to-back zero-amount requests with both sides always willing.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h5A; in_dir = 1'b1; in_amt = 4'd0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("zero_gap", last_gap, 2);

    // Backpressure in HOLD while a new request is waiting.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h3C; in_dir = 1'b1; in_amt = 4'd2;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_data = 8'hF0; in_dir = 1'b0; in_amt = 4'd1;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("bp_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp_stable_data", out_data, 8'h0F);
      check("bp_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("bp_new_latency", n, 1);
    check("bp_new_data", out_data, 8'hE1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the third RUN cycle of a 7-step rotate.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55; in_dir = 1'b0; in_amt = 4'd7;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 8'h00);
    reset = 1'b0;
    send(8'h10, 1'b0, 4'd2, 8'h40, 2, "post_abort");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
